// File: rtl/alu_pkg.sv
// Shared constants for the ALU operand decode stage: datapath widths,
// ALU operation codes, RV32I major opcodes and the funct3 codes used by decode.
package alu_pkg;

  localparam int XLEN   = 32;
  localparam int CTRL_W = 4;

  localparam logic [CTRL_W-1:0] ALU_ADD   = 4'b0000;
  localparam logic [CTRL_W-1:0] ALU_SUB   = 4'b0001;
  localparam logic [CTRL_W-1:0] ALU_AND   = 4'b0010;
  localparam logic [CTRL_W-1:0] ALU_OR    = 4'b0011;
  localparam logic [CTRL_W-1:0] ALU_XOR   = 4'b0100;
  localparam logic [CTRL_W-1:0] ALU_SLL   = 4'b0101;
  localparam logic [CTRL_W-1:0] ALU_SRL   = 4'b0110;
  localparam logic [CTRL_W-1:0] ALU_SRA   = 4'b0111;
  localparam logic [CTRL_W-1:0] ALU_SLT   = 4'b1000;
  localparam logic [CTRL_W-1:0] ALU_SLTU  = 4'b1001;
  localparam logic [CTRL_W-1:0] ALU_LUI   = 4'b1010;
  localparam logic [CTRL_W-1:0] ALU_AUIPC = 4'b1011;
  localparam logic [CTRL_W-1:0] ALU_JAL   = 4'b1100;
  localparam logic [CTRL_W-1:0] ALU_JALR  = 4'b1101;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: sign-extended I/S immediates and the U immediate.
// Only instruction bits [31:7] carry immediate fields, so only those come in.
module imm_gen
  import alu_pkg::*;
#(
  parameter int W = XLEN
) (
  input  logic [31:7]  instr,
  output logic [W-1:0] imm_i,
  output logic [W-1:0] imm_s,
  output logic [W-1:0] imm_u
);

  // Field extraction and sign extension, purely combinational
  always_comb begin
    imm_i = {{(W-11){instr[31]}}, instr[30:20]};
    imm_s = {{(W-11){instr[31]}}, instr[30:25], instr[11:7]};
    imm_u = {{(W-31){instr[31]}}, instr[30:12], 12'b0};
  end

endmodule

// File: rtl/alu_operand_decoder.sv
// Decode stage feeding the ALU: picks A/B operands, encodes the ALU op and
// holds the result in a single valid/ready output register (1-cycle latency).
module alu_operand_decoder
  import alu_pkg::*;
#(
  parameter int XLEN_P = XLEN,
  parameter int CTRL_P = CTRL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [XLEN_P-1:0] in_pc,
  output logic [4:0]        rs1_addr,
  output logic [4:0]        rs2_addr,
  input  logic [XLEN_P-1:0] rs1_data,
  input  logic [XLEN_P-1:0] rs2_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN_P-1:0] A,
  output logic [XLEN_P-1:0] B,
  output logic [CTRL_P-1:0] ALU_control,
  output logic [XLEN_P-1:0] PC,
  output logic [4:0]        rd_addr,
  output logic              reg_write,
  output logic              illegal
);

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [4:0]        rd;
  logic [XLEN_P-1:0] imm_i;
  logic [XLEN_P-1:0] imm_s;
  logic [XLEN_P-1:0] imm_u;
  logic [XLEN_P-1:0] shamt;
  logic [XLEN_P-1:0] dec_a;
  logic [XLEN_P-1:0] dec_b;
  logic [CTRL_P-1:0] dec_ctrl;
  logic              dec_rw;
  logic              dec_ill;
  logic              op_f7_ok;
  logic              in_xfer;

  assign opcode   = in_instr[6:0];
  assign rd       = in_instr[11:7];
  assign funct3   = in_instr[14:12];
  assign funct7   = in_instr[31:25];
  assign rs1_addr = in_instr[19:15];
  assign rs2_addr = in_instr[24:20];
  assign shamt    = {{(XLEN_P-5){1'b0}}, in_instr[24:20]};

  imm_gen #(.W(XLEN_P)) u_imm_gen (
    .instr (in_instr[31:7]),
    .imm_i (imm_i),
    .imm_s (imm_s),
    .imm_u (imm_u)
  );

  // A flush kills the incoming op too, so the stage refuses it that cycle
  assign in_ready = !flush && (!out_valid || out_ready);
  assign in_xfer  = in_valid && in_ready;

  // funct7 0100000 is only meaningful for SUB and SRA on register-register ops
  assign op_f7_ok = (funct7 == F7_BASE) ||
                    ((funct7 == F7_ALT) && ((funct3 == F3_ADD_SUB) || (funct3 == F3_SRL_SRA)));

  // Operand select and ALU op encoding for the instruction on in_instr
  always_comb begin
    dec_a    = '0;
    dec_b    = '0;
    dec_ctrl = ALU_ADD;
    dec_rw   = 1'b0;
    dec_ill  = 1'b0;
    unique case (opcode)
      OPC_OP: begin
        if (op_f7_ok) begin
          dec_a  = rs1_data;
          dec_b  = rs2_data;
          dec_rw = 1'b1;
          unique case (funct3)
            F3_ADD_SUB: dec_ctrl = funct7[5] ? ALU_SUB : ALU_ADD;
            F3_SLL:     dec_ctrl = ALU_SLL;
            F3_SLT:     dec_ctrl = ALU_SLT;
            F3_SLTU:    dec_ctrl = ALU_SLTU;
            F3_XOR:     dec_ctrl = ALU_XOR;
            F3_SRL_SRA: dec_ctrl = funct7[5] ? ALU_SRA : ALU_SRL;
            F3_OR:      dec_ctrl = ALU_OR;
            default:    dec_ctrl = ALU_AND;
          endcase
        end else begin
          dec_ill = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        dec_a  = rs1_data;
        dec_b  = imm_i;
        dec_rw = 1'b1;
        unique case (funct3)
          F3_ADD_SUB: dec_ctrl = ALU_ADD;
          F3_SLL: begin
            dec_b    = shamt;
            dec_ctrl = ALU_SLL;
          end
          F3_SLT:     dec_ctrl = ALU_SLT;
          F3_SLTU:    dec_ctrl = ALU_SLTU;
          F3_XOR:     dec_ctrl = ALU_XOR;
          F3_SRL_SRA: begin
            dec_b    = shamt;
            dec_ctrl = in_instr[30] ? ALU_SRA : ALU_SRL;
          end
          F3_OR:      dec_ctrl = ALU_OR;
          default:    dec_ctrl = ALU_AND;
        endcase
      end
      OPC_LUI: begin
        dec_b    = imm_u;
        dec_ctrl = ALU_LUI;
        dec_rw   = 1'b1;
      end
      OPC_AUIPC: begin
        dec_b    = imm_u;
        dec_ctrl = ALU_AUIPC;
        dec_rw   = 1'b1;
      end
      OPC_JAL: begin
        dec_b    = XLEN_P'(4);
        dec_ctrl = ALU_JAL;
        dec_rw   = 1'b1;
      end
      OPC_JALR: begin
        dec_a    = rs1_data;
        dec_b    = XLEN_P'(4);
        dec_ctrl = ALU_JALR;
        dec_rw   = 1'b1;
      end
      OPC_LOAD: begin
        dec_a  = rs1_data;
        dec_b  = imm_i;
        dec_rw = 1'b1;
      end
      OPC_STORE: begin
        dec_a = rs1_data;
        dec_b = imm_s;
      end
      OPC_BRANCH: begin
        dec_a    = rs1_data;
        dec_b    = rs2_data;
        dec_ctrl = ALU_SUB;
      end
      default: dec_ill = 1'b1;
    endcase
  end

  // Output valid flag: flush wins, then accept, then drain on consume
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (in_xfer) begin
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Data registers load only on an accepted op; x0 never gets a write enable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      A           <= '0;
      B           <= '0;
      ALU_control <= ALU_ADD;
      PC          <= '0;
      rd_addr     <= '0;
      reg_write   <= 1'b0;
      illegal     <= 1'b0;
    end else if (in_xfer) begin
      A           <= dec_a;
      B           <= dec_b;
      ALU_control <= dec_ctrl;
      PC          <= in_pc;
      rd_addr     <= rd;
      reg_write   <= dec_rw && (rd != 5'd0);
      illegal     <= dec_ill;
    end
  end

endmodule

// File: tb/tb_alu_operand_decoder.sv
// Bench for alu_operand_decoder: vector table pushed through a scoreboard
// with random back-pressure, plus stall, flush and async-reset sequences.
module tb_alu_operand_decoder;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  ALU_control;
  logic [31:0] PC;
  logic [4:0]  rd_addr;
  logic        reg_write;
  logic        illegal;

  alu_operand_decoder dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .A           (A),
    .B           (B),
    .ALU_control (ALU_control),
    .PC          (PC),
    .rd_addr     (rd_addr),
    .reg_write   (reg_write),
    .illegal     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic [4:0]  rd;
    logic        rw;
    logic        ill;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];
  vec_t sb_q [$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (vec %0d): got %h expected %h at %0t", name, id, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input int id, input logic [31:0] instr, input logic [31:0] pc,
                              input logic [31:0] rs1, input logic [31:0] rs2,
                              input logic [31:0] a, input logic [31:0] b, input logic [3:0] ctrl,
                              input logic [4:0] rd, input logic rw, input logic ill);
    vec_t v;
    v.id = id; v.instr = instr; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2;
    v.a = a; v.b = b; v.ctrl = ctrl; v.rd = rd; v.rw = rw; v.ill = ill;
    return v;
  endfunction

  // Scoreboard: every consumed op must match the oldest accepted op
  always @(negedge clk) begin
    if (!rst && !flush && out_valid && out_ready) begin
      vec_t e;
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_output", -1, 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("A", e.id, A, e.a);
        chk("B", e.id, B, e.b);
        chk("ALU_control", e.id, {28'd0, ALU_control}, {28'd0, e.ctrl});
        chk("PC", e.id, PC, e.pc);
        chk("rd_addr", e.id, {27'd0, rd_addr}, {27'd0, e.rd});
        chk("reg_write", e.id, {31'd0, reg_write}, {31'd0, e.rw});
        chk("illegal", e.id, {31'd0, illegal}, {31'd0, e.ill});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    in_valid = 1'b1;
    in_instr = v.instr;
    in_pc    = v.pc;
    rs1_data = v.rs1;
    rs2_data = v.rs2;
  endtask

  // Present one op until accepted, with optional random back-pressure
  task automatic send(input vec_t v, input bit rand_ready);
    bit done = 1'b0;
    int n = 0;
    drive(v);
    while (!done && n < 50) begin
      out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      if (n == 0) begin
        chk("rs1_addr", v.id, {27'd0, rs1_addr}, {27'd0, v.instr[19:15]});
        chk("rs2_addr", v.id, {27'd0, rs2_addr}, {27'd0, v.instr[24:20]});
      end
      if (in_ready) begin
        sb_q.push_back(v);
        done = 1'b1;
      end
      step();
      n++;
    end
    in_valid = 1'b0;
    chk("accept_within_budget", v.id, {31'd0, done}, 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (sb_q.size() != 0 && n < 20) begin
      step();
      n++;
    end
    step();
    chk("drain_queue_empty", -1, sb_q.size(), 32'd0);
    chk("drain_out_valid", -1, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    vecs[0]  = mk(0,  32'h002081B3, 32'd0,   32'd10,  32'd5,  32'd10,  32'd5,  4'h0, 5'd3,  1'b1, 1'b0);
    vecs[1]  = mk(1,  32'h402081B3, 32'd4,   32'd10,  32'd5,  32'd10,  32'd5,  4'h1, 5'd3,  1'b1, 1'b0);
    vecs[2]  = mk(2,  32'h4030D093, 32'd8,   32'hF0,  32'h55, 32'hF0,  32'd3,  4'h7, 5'd1,  1'b1, 1'b0);
    vecs[3]  = mk(3,  32'h123452B7, 32'd12,  32'h77,  32'h88, 32'd0,   32'h12345000, 4'hA, 5'd5, 1'b1, 1'b0);
    vecs[4]  = mk(4,  32'h00001317, 32'd100, 32'h77,  32'h88, 32'd0,   32'h1000, 4'hB, 5'd6, 1'b1, 1'b0);
    vecs[5]  = mk(5,  32'h008000EF, 32'd200, 32'h77,  32'h88, 32'd0,   32'd4,  4'hC, 5'd1,  1'b1, 1'b0);
    vecs[6]  = mk(6,  32'h00000013, 32'd204, 32'd0,   32'h88, 32'd0,   32'd0,  4'h0, 5'd0,  1'b0, 1'b0);
    vecs[7]  = mk(7,  32'h00000073, 32'd208, 32'h77,  32'h88, 32'd0,   32'd0,  4'h0, 5'd0,  1'b0, 1'b1);
    vecs[8]  = mk(8,  32'hFFF10393, 32'd212, 32'd20,  32'h88, 32'd20,  32'hFFFFFFFF, 4'h0, 5'd7, 1'b1, 1'b0);
    vecs[9]  = mk(9,  32'hFE512E23, 32'd216, 32'h1000, 32'h99, 32'h1000, 32'hFFFFFFFC, 4'h0, 5'd28, 1'b0, 1'b0);
    vecs[10] = mk(10, 32'h0101A403, 32'd220, 32'h200, 32'h99, 32'h200, 32'd16, 4'h0, 5'd8,  1'b1, 1'b0);
    vecs[11] = mk(11, 32'h00208463, 32'd224, 32'd7,   32'd9,  32'd7,   32'd9,  4'h1, 5'd8,  1'b0, 1'b0);
    vecs[12] = mk(12, 32'h022081B3, 32'd228, 32'd7,   32'd9,  32'd0,   32'd0,  4'h0, 5'd3,  1'b0, 1'b1);
    vecs[13] = mk(13, 32'h000280E7, 32'd232, 32'h3000, 32'h99, 32'h3000, 32'd4, 4'hD, 5'd1, 1'b1, 1'b0);
    vecs[14] = mk(14, 32'h01F09213, 32'd236, 32'd1,   32'h99, 32'd1,   32'd31, 4'h5, 5'd4,  1'b1, 1'b0);
    vecs[15] = mk(15, 32'h0020B1B3, 32'd240, 32'd1,   32'd2,  32'd1,   32'd2,  4'h9, 5'd3,  1'b1, 1'b0);
    vecs[16] = mk(16, 32'h4020D1B3, 32'd244, 32'h80000000, 32'd4, 32'h80000000, 32'd4, 4'h7, 5'd3, 1'b1, 1'b0);
    vecs[17] = mk(17, 32'h0020F1B3, 32'd248, 32'hF0F0, 32'hFF00, 32'hF0F0, 32'hFF00, 4'h2, 5'd3, 1'b1, 1'b0);

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0; rs1_data = '0; rs2_data = '0;
    #2;
    chk("reset_out_valid", -1, {31'd0, out_valid}, 32'd0);
    chk("reset_A", -1, A, 32'd0);
    chk("reset_B", -1, B, 32'd0);
    chk("reset_ctrl", -1, {28'd0, ALU_control}, 32'd0);
    chk("reset_PC", -1, PC, 32'd0);
    chk("reset_reg_write", -1, {31'd0, reg_write}, 32'd0);
    #10 rst = 1'b0;
    step();

    // table: back-to-back first, then with random back-pressure
    for (int i = 0; i < NVEC; i++) send(vecs[i], 1'b0);
    drain();
    for (int i = 0; i < NVEC; i++) send(vecs[i], 1'b1);
    drain();

    // stall: held op stays put and the next op waits
    drive(vecs[0]);
    out_ready = 1'b1;
    @(negedge clk);
    if (in_ready) sb_q.push_back(vecs[0]);
    step();
    drive(vecs[1]);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_in_ready", k, {31'd0, in_ready}, 32'd0);
      chk("stall_out_valid", k, {31'd0, out_valid}, 32'd1);
      chk("stall_A", k, A, 32'd10);
      chk("stall_ctrl", k, {28'd0, ALU_control}, 32'd0);
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready", -1, {31'd0, in_ready}, 32'd1);
    if (in_ready) sb_q.push_back(vecs[1]);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("release_next_valid", -1, {31'd0, out_valid}, 32'd1);
    chk("release_next_ctrl", -1, {28'd0, ALU_control}, 32'd1);
    drain();

    // flush with a held op and an incoming op
    drive(vecs[3]);
    out_ready = 1'b0;
    @(negedge clk);
    if (in_ready) sb_q.push_back(vecs[3]);
    step();
    drive(vecs[5]);
    flush = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", -1, {31'd0, in_ready}, 32'd0);
    sb_q.delete();
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", -1, {31'd0, out_valid}, 32'd0);
    step();

    // async reset mid-stream
    drive(vecs[16]);
    out_ready = 1'b0;
    @(negedge clk);
    if (in_ready) sb_q.push_back(vecs[16]);
    step();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out_valid", -1, {31'd0, out_valid}, 32'd0);
    chk("async_rst_A", -1, A, 32'd0);
    chk("async_rst_B", -1, B, 32'd0);
    chk("async_rst_PC", -1, PC, 32'd0);
    chk("async_rst_rd", -1, {27'd0, rd_addr}, 32'd0);
    chk("async_rst_reg_write", -1, {31'd0, reg_write}, 32'd0);
    sb_q.delete();
    @(negedge clk);
    #2 rst = 1'b0;
    step();
    drive(vecs[4]);
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", -1, {31'd0, in_ready}, 32'd1);
    if (in_ready) sb_q.push_back(vecs[4]);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_out_valid", -1, {31'd0, out_valid}, 32'd1);
    step();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
